// File: rtl/pos_sweep_pkg.sv
// Shared types and constants for the truth-table sweep/check engine.
package pos_sweep_pkg;

    localparam int unsigned N_VEC                = 16;
    localparam logic [15:0] POS_EXPECTED_DEFAULT = 16'hAC3C;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/pos_sweep_timer.sv
// Settle counter: counts while enabled, clears on request, flags terminal count SETTLE-1.
module pos_sweep_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_tc = (r_count == 4'(SETTLE - 1));

endmodule

// File: rtl/pos_sweep_checker.sv
// Sweeps all 16 minterms into a 4-input function block and checks the captured truth table.
// Optional macro POS_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first failing minterm.
module pos_sweep_checker
    import pos_sweep_pkg::*;
#(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = POS_EXPECTED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        s_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_q,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail
);

    sweep_state_t r_state;
    logic [3:0]   r_idx;
    logic [3:0]   r_abcd;
    logic         r_busy;
    logic         r_done;
    logic         r_pass;
    logic [15:0]  r_table;
    logic [4:0]   r_mis;
    logic [3:0]   r_ff;

    logic         w_start_ok;
    logic         w_tc;
    logic         w_mismatch;
    logic         w_last;
    logic         w_finish;
    logic [4:0]   w_mis_next;

    pos_sweep_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_start_ok || (r_state == SAMPLE)),
        .i_en  (r_state == DRIVE),
        .o_tc  (w_tc)
    );

    // Case inequality so an x/z sample is always reported as a failure.
    always_comb begin
        w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
        w_mismatch = (s_in !== EXPECTED[r_idx]);
        w_last     = (r_idx == 4'(N_VEC - 1));
        w_mis_next = r_mis + {4'b0000, w_mismatch};
`ifdef POS_SWEEP_STOP_ON_FAIL_EN
        w_finish   = w_last || w_mismatch;
`else
        w_finish   = w_last;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_abcd  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_table <= '0;
            r_mis   <= '0;
            r_ff    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state <= DRIVE;
                        r_idx   <= '0;
                        r_abcd  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_table <= '0;
                        r_mis   <= '0;
                        r_ff    <= '0;
                    end
                end
                DRIVE: begin
                    if (w_tc) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_table[r_idx] <= s_in;
                    r_mis          <= w_mis_next;
                    if (w_mismatch && (r_mis == '0)) begin
                        r_ff <= r_idx;
                    end
                    if (w_finish) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mis_next == '0);
                    end else begin
                        r_state <= DRIVE;
                        r_idx   <= r_idx + 4'd1;
                        r_abcd  <= r_idx + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign abcd           = r_abcd;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign table_q        = r_table;
    assign mismatch_count = r_mis;
    assign first_fail     = r_ff;

endmodule

// File: tb/tb_pos_sweep_checker.sv
// Directed bench: PoS function block in the loop, tied-off inputs, SETTLE=3 timing, reset and restart corners.
module tb_pos_sweep_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    int          mode = 0;

    logic [3:0]  abcd1, abcd3;
    logic        s1, s3;
    logic        busy1, done1, pass1;
    logic        busy3, done3, pass3;
    logic [15:0] tbl1, tbl3;
    logic [4:0]  cnt1, cnt3;
    logic [3:0]  ff1, ff3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Product-of-sums block under test: zeros at minterms 0,1,6,7,8,9,12,14.
    function automatic logic pos_fn(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (b | c) & (a | ~b | ~c) & (~a | ~b | d);
    endfunction

    assign s1 = (mode == 0) ? pos_fn(abcd1) : (mode == 1) ? 1'b0 : 1'b1;
    assign s3 = pos_fn(abcd3);

    pos_sweep_checker #(.SETTLE(1), .EXPECTED(16'hAC3C)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .abcd(abcd1), .s_in(s1),
        .busy(busy1), .done(done1), .pass(pass1), .table_q(tbl1),
        .mismatch_count(cnt1), .first_fail(ff1)
    );

    pos_sweep_checker #(.SETTLE(3), .EXPECTED(16'hAC3C)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abcd(abcd3), .s_in(s3),
        .busy(busy3), .done(done3), .pass(pass3), .table_q(tbl3),
        .mismatch_count(cnt3), .first_fail(ff3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Starts a sweep on the SETTLE=1 instance; optionally re-pulses start when abcd hits poke_at.
    task automatic run1(input int m, input bit poke, input logic [3:0] poke_at, output int n);
        bit poked;
        poked  = 1'b0;
        mode   = m;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            if (poke && !poked && abcd1 == poke_at) begin
                poked  = 1'b1;
                start1 = 1'b1;
            end
            tick();
            start1 = 1'b0;
            n++;
        end
    endtask

    typedef struct {
        int          mode;
        int          cyc;
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic [3:0]  ff;
        logic        pass;
        logic [3:0]  abcd;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int n;
        int stable_err;

`ifdef POS_SWEEP_STOP_ON_FAIL_EN
        vecs[0] = '{0, 32, 16'hAC3C, 5'd0, 4'd0, 1'b1, 4'd15};
        vecs[1] = '{1, 6,  16'h0000, 5'd1, 4'd2, 1'b0, 4'd2};
        vecs[2] = '{2, 2,  16'h0001, 5'd1, 4'd0, 1'b0, 4'd0};
`else
        vecs[0] = '{0, 32, 16'hAC3C, 5'd0, 4'd0, 1'b1, 4'd15};
        vecs[1] = '{1, 32, 16'h0000, 5'd8, 4'd2, 1'b0, 4'd15};
        vecs[2] = '{2, 32, 16'hFFFF, 5'd8, 4'd0, 1'b0, 4'd15};
`endif

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_abcd",  32'(abcd1), 32'h0);
        chk("rst_busy",  32'(busy1), 32'h0);
        chk("rst_done",  32'(done1), 32'h0);
        chk("rst_pass",  32'(pass1), 32'h0);
        chk("rst_table", 32'(tbl1),  32'h0);
        chk("rst_cnt",   32'(cnt1),  32'h0);
        chk("rst_ff",    32'(ff1),   32'h0);

        for (int i = 0; i < 3; i++) begin
            run1(vecs[i].mode, 1'b0, 4'd0, n);
            chk("vec_cycles", 32'(n),          32'(vecs[i].cyc));
            chk("vec_table",  32'(tbl1),       32'(vecs[i].tbl));
            chk("vec_cnt",    32'(cnt1),       32'(vecs[i].cnt));
            chk("vec_ff",     32'(ff1),        32'(vecs[i].ff));
            chk("vec_pass",   32'(pass1),      32'(vecs[i].pass));
            chk("vec_abcd",   32'(abcd1),      32'(vecs[i].abcd));
            chk("vec_busy",   32'(busy1),      32'h0);
        end

        // done/pass must hold with no new start
        tick();
        tick();
        tick();
        chk("done_hold", 32'(done1), 32'h1);

        // start during a sweep is ignored; finish time unchanged
        run1(0, 1'b1, 4'd7, n);
        chk("restart_cycles", 32'(n),     32'd32);
        chk("restart_pass",   32'(pass1), 32'h1);
        chk("restart_table",  32'(tbl1),  32'hAC3C);

        // synchronous reset mid-sweep at abcd=5
        mode   = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (abcd1 != 4'd5 && n < 100) begin
            tick();
            n++;
        end
        chk("reach_abcd5", 32'(abcd1), 32'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_abcd",  32'(abcd1), 32'h0);
        chk("mid_rst_busy",  32'(busy1), 32'h0);
        chk("mid_rst_done",  32'(done1), 32'h0);
        chk("mid_rst_table", 32'(tbl1),  32'h0);
        chk("mid_rst_cnt",   32'(cnt1),  32'h0);
        tick();
        tick();
        chk("idle_stays", 32'({busy1, abcd1}), 32'h0);
        run1(0, 1'b0, 4'd0, n);
        chk("post_rst_cycles", 32'(n),     32'd32);
        chk("post_rst_pass",   32'(pass1), 32'h1);

        // SETTLE=3: each vector held 4 cycles, done after 64
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        stable_err = 0;
        while (!done3 && n < 400) begin
            if (abcd3 != 4'(n / 4)) stable_err++;
            tick();
            n++;
        end
        chk("s3_stable", 32'(stable_err), 32'h0);
        chk("s3_cycles", 32'(n),          32'd64);
        chk("s3_pass",   32'(pass3),      32'h1);
        chk("s3_table",  32'(tbl3),       32'hAC3C);
        chk("s3_cnt",    32'(cnt3),       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
